cache_stats_unit: RTL and testbench
===================================

# cache_stats_unit

Synthesizable per-cache hit/miss/read/write statistics collector, the hardware successor of the simulation-only counters in the cache top level. It sits beside the processor, observes one trace command per cycle from any of CHANNELS caches, and keeps saturating per-channel counters. Command 8 clears them. Command 9 snapshots them and streams the snapshot out over a valid/ready dump port.

## Interface
- CHANNELS, 2, number of caches observed (0 = data, 1 = instruction); ≥1
- CNT_W, 32, counter width in bits; ≥4
- CH_W, $clog2(CHANNELS) (min 1), channel index width (derived localparam)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- ev_valid  in  1  event qualifier
- ev_n  in  4  trace command code
- ev_chan  in  CH_W  cache that serviced the event
- ev_hit  in  1  1 = hit, 0 = miss (ignored for codes 8/9)
- dump_valid  out  1  dump beat available
- dump_ready  in  1  consumer accepts beat
- dump_chan  out  CH_W  channel of current beat
- dump_sel  out  2  stat_sel_t: READ=0, WRITE=1, HIT=2, MISS=3
- dump_data  out  CNT_W  snapshot value
- dump_last  out  1  final beat of dump
- dump_busy  out  1  dump in progress
- sat  out  CHANNELS  sticky per-channel saturation flag
- ev_err  out  1  one-cycle pulse: bad channel or unknown code

## Operation
- Accepted event: ev_valid=1 at rising edge.
- Codes 0,2,4: READ[chan]+1. Codes 1,3: WRITE[chan]+1.
- Codes 0–4: HIT[chan]+1 if ev_hit, else MISS[chan]+1.
- Code 8: clear all live counters and sat. Snapshot and any running dump are unaffected.
- Code 9, state IDLE: copy all live counters into snapshot, enter DUMP.
- Code 9, state DUMP: ignored, no error.
- Codes 5,6,7,10–15: no counter change; ev_err pulses.
- ev_chan ≥ CHANNELS with a code in 0–4: no counter change; ev_err pulses.
- Saturation: a counter at 2^CNT_W−1 holds its value; the increment attempt sets sat[chan].
- FSM IDLE → DUMP on an accepted code 9.
- In DUMP, beat order: chan 0..CHANNELS−1, sel READ, WRITE, HIT, MISS within each chan; 4·CHANNELS beats total.
- A beat completes when dump_valid & dump_ready. dump_last=1 on the final beat; its completion returns the FSM to IDLE.
- Live counters keep counting during DUMP.

## Timing
- Reset values: every counter and snapshot = 0; sat=0; ev_err=0; dump_valid=0; dump_busy=0; dump_last=0; dump_chan=0; dump_sel=0; dump_data=0; FSM=IDLE.
- Counter update is visible one cycle after the accepting edge.
- Snapshot includes every event accepted before the code 9 edge.
- dump_valid and dump_busy rise the cycle after code 9 is accepted.
- dump_chan, dump_sel, dump_data and dump_last stay stable while dump_valid=1 and dump_ready=0.
- Back-to-back beats: with dump_ready held at 1, a full dump takes 4·CHANNELS cycles.
- dump_valid and dump_busy fall the cycle after the last handshake.
- A code 9 accepted in the same cycle as that last handshake is ignored (FSM still DUMP).
- Reset asserted mid-dump aborts immediately to reset values; no partial beat survives.

## Structure
- Add to my_struct_package: stat_sel_t enum and command-code constants CMD_RESET=8, CMD_PRINT=9.
- Sub-module cache_stats_counter: CNT_W-bit saturating counter with inc, clr and sat_pulse.
- Instantiate cache_stats_counter 4·CHANNELS times via generate.
- Snapshot array and dump FSM live in the top block.

## Test plan
- Reset, then events (0,ch0,hit), (1,ch0,miss), (2,ch1,miss), then code 9 → 8 beats: ch0 R=1 W=1 H=1 M=1; ch1 R=1 W=0 H=0 M=1; dump_last only on ch1 MISS.
- CNT_W=4, 17 × (0,ch0,hit) → ch0 HIT=15, READ=15, sat[0]=1. Then code 8 → all counters 0, sat=0.
- Code 9 with dump_ready held low for 5 cycles, then 1 → beat 0 stable for 5 cycles; total dump 4·CHANNELS+5 cycles.
- During a dump, issue (3,ch0,hit) then code 9 → dump data shows pre-snapshot values; second 9 ignored. The next code 9 in IDLE dumps WRITE[0] and HIT[0] each incremented by 1.
- Code 6, and (0, ev_chan=CHANNELS) → ev_err pulses one cycle each; all counters unchanged.
- Assert rst on the third dump beat → dump_valid=0 and dump_busy=0 immediately. A later code 9 dumps all zeros.

Source files
------------

// File: rtl/cache_stats_unit_pkg.sv
// Shared types and command codes for the cache statistics collector.
package cache_stats_unit_pkg;

  typedef enum logic [1:0] {
    SEL_READ  = 2'd0,
    SEL_WRITE = 2'd1,
    SEL_HIT   = 2'd2,
    SEL_MISS  = 2'd3
  } stat_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_t;

  localparam logic [3:0] CMD_RESET       = 4'd8;
  localparam logic [3:0] CMD_PRINT       = 4'd9;
  localparam logic [3:0] CMD_LAST_ACCESS = 4'd4;

  function automatic logic is_read_cmd(input logic [3:0] n);
    return (n == 4'd0) || (n == 4'd2) || (n == 4'd4);
  endfunction

  function automatic logic is_write_cmd(input logic [3:0] n);
    return (n == 4'd1) || (n == 4'd3);
  endfunction

endpackage

// File: rtl/cache_stats_counter.sv
// Saturating event counter: holds at all-ones and flags the overflowing increment.
module cache_stats_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat_pulse
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full      = &r_count;
  assign o_sat_pulse = i_inc & w_full;
  assign o_count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_stats_unit.sv
// Per-cache read/write/hit/miss statistics with clear, snapshot and
// valid/ready streaming of the snapshot.
module cache_stats_unit
  import cache_stats_unit_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int CNT_W    = 32,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev_valid,
  input  logic [3:0]          ev_n,
  input  logic [CH_W-1:0]     ev_chan,
  input  logic                ev_hit,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [CH_W-1:0]     dump_chan,
  output logic [1:0]          dump_sel,
  output logic [CNT_W-1:0]    dump_data,
  output logic                dump_last,
  output logic                dump_busy,
  output logic [CHANNELS-1:0] sat,
  output logic                ev_err
);

  logic [(1<<CH_W)-1:0] w_chan_ok;
  logic                 w_code_cnt;
  logic                 w_cnt_ev;
  logic                 w_err_nxt;
  logic                 w_clear;
  logic                 w_start;
  logic                 w_fire;
  logic                 w_last_beat;
  logic [CHANNELS-1:0]  w_ch_sel;
  logic [3:0]           w_inc  [CHANNELS];
  logic [3:0]           w_satp [CHANNELS];
  logic [CNT_W-1:0]     w_cnt  [CHANNELS][4];

  logic [CNT_W-1:0]     r_snap [CHANNELS][4];
  logic [CHANNELS-1:0]  r_sat;
  logic                 r_ev_err;
  dump_state_t          r_state;
  dump_state_t          w_state_nxt;
  logic [CH_W-1:0]      r_chan;
  logic [1:0]           r_sel;

  // Channel codes beyond CHANNELS-1 are representable when CHANNELS is not a power of two.
  for (genvar i = 0; i < (1 << CH_W); i++) begin : g_chan_ok
    assign w_chan_ok[i] = (i < CHANNELS);
  end

  assign w_code_cnt = (ev_n <= CMD_LAST_ACCESS);
  assign w_cnt_ev   = ev_valid & w_code_cnt & w_chan_ok[ev_chan];
  assign w_err_nxt  = ev_valid & (((ev_n >= 4'd5) & (ev_n <= 4'd7)) | (ev_n >= 4'd10) |
                                  (w_code_cnt & ~w_chan_ok[ev_chan]));
  assign w_clear    = ev_valid & (ev_n == CMD_RESET);
  assign w_start    = ev_valid & (ev_n == CMD_PRINT) & (r_state == ST_IDLE);
  assign w_fire     = (r_state == ST_DUMP) & dump_ready;
  assign w_last_beat = (r_chan == CH_W'(CHANNELS - 1)) & (r_sel == SEL_MISS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign w_ch_sel[c] = w_cnt_ev & (ev_chan == CH_W'(c));
    assign w_inc[c] = {w_ch_sel[c] & ~ev_hit,
                       w_ch_sel[c] &  ev_hit,
                       w_ch_sel[c] &  is_write_cmd(ev_n),
                       w_ch_sel[c] &  is_read_cmd(ev_n)};
    for (genvar s = 0; s < 4; s++) begin : g_sel
      cache_stats_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_inc[c][s]),
        .i_clr       (w_clear),
        .o_count     (w_cnt[c][s]),
        .o_sat_pulse (w_satp[c][s])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat    <= '0;
      r_ev_err <= 1'b0;
    end else begin
      r_ev_err <= w_err_nxt;
      if (w_clear) begin
        r_sat <= '0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (|w_satp[c]) r_sat[c] <= 1'b1;
        end
      end
    end
  end

  assign sat    = r_sat;
  assign ev_err = r_ev_err;

  // Snapshot captures live counters as they stood before the print edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s < 4; s++) r_snap[c][s] <= '0;
      end
    end else if (w_start) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s < 4; s++) r_snap[c][s] <= w_cnt[c][s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)                w_state_nxt = ST_DUMP;
      ST_DUMP: if (w_fire && w_last_beat)  w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chan <= '0;
      r_sel  <= '0;
    end else if (w_start) begin
      r_chan <= '0;
      r_sel  <= '0;
    end else if (w_fire) begin
      r_sel <= r_sel + 2'd1;
      if (r_sel == SEL_MISS) r_chan <= w_last_beat ? '0 : r_chan + 1'b1;
    end
  end

  always_comb begin
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_chan  = '0;
    dump_sel   = '0;
    dump_data  = '0;
    dump_last  = 1'b0;
    if (r_state == ST_DUMP) begin
      dump_valid = 1'b1;
      dump_busy  = 1'b1;
      dump_chan  = r_chan;
      dump_sel   = r_sel;
      dump_data  = r_snap[r_chan][r_sel];
      dump_last  = w_last_beat;
    end
  end

endmodule

// File: tb/tb_cache_stats_unit.sv
// Randomized and directed bench for cache_stats_unit against a cycle-level behavioural model.
module tb_cache_stats_unit;

  localparam int CH    = 3;
  localparam int CW    = 4;
  localparam int CHW   = 2;
  localparam int NB    = 4 * CH;
  localparam int MAXV  = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           ev_valid;
  logic [3:0]     ev_n;
  logic [CHW-1:0] ev_chan;
  logic           ev_hit;
  logic           dump_valid;
  logic           dump_ready;
  logic [CHW-1:0] dump_chan;
  logic [1:0]     dump_sel;
  logic [CW-1:0]  dump_data;
  logic           dump_last;
  logic           dump_busy;
  logic [CH-1:0]  sat;
  logic           ev_err;

  cache_stats_unit #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_n       (ev_n),
    .ev_chan    (ev_chan),
    .ev_hit     (ev_hit),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_chan  (dump_chan),
    .dump_sel   (dump_sel),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .dump_busy  (dump_busy),
    .sat        (sat),
    .ev_err     (ev_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: counters per channel in order READ, WRITE, HIT, MISS; snapshot flattened by beat number.
  int            m_cnt [CH][4];
  int            m_snap [NB];
  logic [CH-1:0] m_sat;
  bit            m_err;
  bit            m_active;
  int            m_beat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) for (int s = 0; s < 4; s++) m_cnt[c][s] = 0;
    for (int b = 0; b < NB; b++) m_snap[b] = 0;
    m_sat = '0; m_err = 0; m_active = 0; m_beat = 0;
  endtask

  task automatic bump(input int c, input int s);
    if (m_cnt[c][s] == MAXV) m_sat[c] = 1'b1;
    else m_cnt[c][s]++;
  endtask

  task automatic model_step(input bit v, input int n, input int ch, input bit h, input bit rdy);
    bit fire, start;
    fire  = m_active && rdy;
    start = v && (n == 9) && !m_active;
    m_err = v && (((n >= 5) && (n != 8) && (n != 9)) || ((n <= 4) && (ch >= CH)));
    if (start) for (int c = 0; c < CH; c++) for (int s = 0; s < 4; s++) m_snap[c*4+s] = m_cnt[c][s];
    if (v && (n <= 4) && (ch < CH)) begin
      bump(ch, (n == 1 || n == 3) ? 1 : 0);
      bump(ch, h ? 2 : 3);
    end
    if (v && (n == 8)) begin
      for (int c = 0; c < CH; c++) for (int s = 0; s < 4; s++) m_cnt[c][s] = 0;
      m_sat = '0;
    end
    if (fire) begin
      if (m_beat == NB - 1) m_active = 0;
      else m_beat++;
    end
    if (start) begin
      m_active = 1; m_beat = 0;
    end
  endtask

  task automatic check_outputs();
    chk("dump_valid", dump_valid, m_active);
    chk("dump_busy", dump_busy, m_active);
    chk("sat", sat, m_sat);
    chk("ev_err", ev_err, m_err);
    if (m_active) begin
      chk("dump_chan", dump_chan, m_beat / 4);
      chk("dump_sel", dump_sel, m_beat % 4);
      chk("dump_data", dump_data, m_snap[m_beat]);
      chk("dump_last", dump_last, (m_beat == NB - 1));
    end else begin
      chk("dump_last_idle", dump_last, 0);
    end
  endtask

  // Drive one cycle: inputs set, outputs checked, edge, model advanced, settle past the edge.
  task automatic cycle(input bit v, input int n, input int ch, input bit h, input bit rdy);
    ev_valid = v; ev_n = n[3:0]; ev_chan = ch[CHW-1:0]; ev_hit = h; dump_ready = rdy;
    check_outputs();
    @(posedge clk);
    model_step(v, n, ch, h, rdy);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && m_active; k++) cycle(0, 0, 0, 0, 1);
    chk("drain_done", dump_busy, 0);
  endtask

  int busy_cycles;

  initial begin
    rst = 1'b1; ev_valid = 0; ev_n = 0; ev_chan = 0; ev_hit = 0; dump_ready = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs();
    chk("rst_chan", dump_chan, 0);
    chk("rst_sel", dump_sel, 0);
    chk("rst_data", dump_data, 0);

    // Basic mix then a full back-to-back dump
    cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 2, 1, 0, 1);
    cycle(1, 9, 0, 0, 1);
    busy_cycles = 0;
    for (int k = 0; k < 100 && dump_busy; k++) begin busy_cycles++; cycle(0, 0, 0, 0, 1); end
    chk("dump_len", busy_cycles, NB);

    // Saturation then clear
    for (int k = 0; k < 17; k++) cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    chk("sat_after_17", sat, 3'b001);
    cycle(1, 9, 0, 0, 1); drain();
    cycle(1, 8, 0, 0, 1);
    cycle(1, 9, 0, 0, 1); drain();

    // Stalled first beat
    cycle(1, 0, 2, 1, 0);
    cycle(1, 9, 0, 0, 0);
    busy_cycles = 0;
    for (int k = 0; k < 5; k++) begin busy_cycles += dump_busy; cycle(0, 0, 0, 0, 0); end
    for (int k = 0; k < 100 && dump_busy; k++) begin busy_cycles++; cycle(0, 0, 0, 0, 1); end
    chk("stall_len", busy_cycles, NB + 5);

    // Events and a second print during a dump; print on the last handshake is ignored
    cycle(1, 9, 0, 0, 1);
    cycle(1, 3, 0, 1, 1);
    cycle(1, 9, 0, 0, 1);
    for (int k = 0; k < 100 && m_beat != NB - 1; k++) cycle(0, 0, 0, 0, 1);
    cycle(1, 9, 0, 0, 1);
    chk("print_on_last_ignored", dump_busy, 0);
    cycle(1, 9, 0, 0, 1); drain();

    // Error pulses with no counter change
    cycle(1, 6, 0, 1, 1);
    cycle(1, 0, CH, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 9, 0, 0, 1); drain();

    // Reset on the third beat
    cycle(1, 9, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("third_beat_sel", dump_sel, 2);
    ev_valid = 0; rst = 1'b1; #1;
    chk("rst_mid_valid", dump_valid, 0);
    chk("rst_mid_busy", dump_busy, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, 9, 0, 0, 1); drain();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int r, n;
      r = int'($urandom % 64);
      if (r < 50)       n = int'($urandom % 5);
      else if (r < 58)  n = 9;
      else if (r == 58) n = 8;
      else              n = int'($urandom % 16);
      cycle(($urandom % 4) != 0, n, int'($urandom % 4), $urandom % 2, ($urandom % 3) != 0);
    end
    drain();
    cycle(1, 9, 0, 0, 1); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
